laser_fire_ctrl: RTL
====================

# laser_fire_ctrl

Trigger-side controller that sits directly upstream of the laser driver. It debounces the raw trigger and reload buttons and meters shots against an ammo count. It generates the active-low `fire_n` level consumed by the laser driver's `in` input. Each accepted shot holds `fire_n` low for a fixed burst, then enforces a cooldown before the next shot.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized button must stay stable before its new level is accepted (10 ms @ 50 MHz).
- `SHOT_CYCLES`, 25000000: cycles `fire_n` is held low per shot; must be < 150000000 (laser driver timeout).
- `COOLDOWN_CYCLES`, 50000000: cycles after a shot before the next shot may start.
- `RELOAD_CYCLES`, 100000000: duration of the reload sequence.
- `AMMO_MAX`, 8: shots per magazine, 1..15.
- `clock`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  raw trigger button, 1 = pressed, asynchronous to `clock`.
- `reload`  in  1  raw reload button, 1 = pressed, asynchronous to `clock`.
- `fire_n`  out  1  to laser driver `in`; 0 = laser on, 1 = off.
- `ammo`  out  4  remaining shots.
- `busy`  out  1  1 in FIRE, COOLDOWN or RELOAD.
- `empty`  out  1  1 when `ammo` == 0.

## Operation
- Each button passes through a 2-flop synchronizer, then a stability counter. The debounced level updates only after `DEBOUNCE_CYCLES` consecutive equal samples. Press event = debounced 0→1 transition, a single-cycle pulse.
- FSM states: IDLE, FIRE, COOLDOWN, RELOAD.
- IDLE → FIRE on trigger press event when `ammo` > 0. On entry, `ammo` decrements by 1 and the phase counter clears.
- FIRE → COOLDOWN when the phase counter reaches `SHOT_CYCLES`-1.
- COOLDOWN → IDLE when the phase counter reaches `COOLDOWN_CYCLES`-1.
- IDLE → RELOAD on reload press event, unless a trigger press event with `ammo` > 0 occurs in the same cycle (trigger wins). RELOAD is allowed at any ammo level, including full.
- RELOAD → IDLE when the phase counter reaches `RELOAD_CYCLES`-1. `ammo` := `AMMO_MAX` on that transition.
- Press events outside IDLE are discarded, not queued. A trigger press with `ammo` == 0 is discarded.
- `fire_n` = 0 exactly while in FIRE; registered output.
- `empty` and `busy` are registered and consistent with the state and `ammo` of the same cycle.
- Phase counter: 32-bit unsigned, cleared on every state entry; no wrap is possible within the legal parameter ranges.

## Timing
- Reset values (asynchronous): state IDLE, `fire_n`=1, `ammo`=`AMMO_MAX`, `busy`=0, `empty`=0. All debounced levels are 0, synchronizers are 0, and counters are 0.
- Button to press event: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- Press event in cycle t → `fire_n`=0, `busy`=1 and decremented `ammo` visible from cycle t+1.
- `fire_n` is low for exactly `SHOT_CYCLES` cycles, then high for at least `COOLDOWN_CYCLES` cycles before any later low.
- Reload completion: `ammo`=`AMMO_MAX`, `empty`=0 and `busy`=0 are visible in the same cycle.
- `resetn` asserted mid-shot: `fire_n` goes to 1 immediately (asynchronously) and the shot is not resumed.

## Configuration
- `LASER_FIRE_AUTO_EN` defined: at the COOLDOWN end, if the debounced trigger level is still 1 and `ammo` > 0, transition directly COOLDOWN → FIRE. This gives auto-fire with no idle cycle; `ammo` decrements as on a normal entry.
- Not defined: every shot requires a fresh press event seen in IDLE; holding the trigger fires exactly once.

## Structure
- Shared package: FSM state encoding (2-bit enum: IDLE, FIRE, COOLDOWN, RELOAD), the 32-bit counter width constant, and the laser-driver timeout constant 150000000 used for the `SHOT_CYCLES` check.
- One sub-module, `button_debounce` (2-flop sync + stability counter; outputs `level` and `press`), instantiated twice.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, SHOT_CYCLES=10, COOLDOWN_CYCLES=6, RELOAD_CYCLES=20, AMMO_MAX=3.
- Trigger pulse of 2 cycles → no press event; `fire_n` stays 1 and `ammo` stays 3.
- Clean trigger press → `fire_n` low for exactly 10 cycles starting 7 cycles after the press (2 sync + 4 debounce + 1), `ammo`=2, `busy` high for 16 cycles.
- Three separate presses, then a fourth → three 10-cycle shots, `ammo`=0, `empty`=1; the fourth press leaves `fire_n`=1.
- Reload press while `empty` → `busy`=1 for 20 cycles, then `ammo`=3 and `empty`=0; a trigger press during RELOAD is ignored.
- Trigger held for 100 cycles → one shot without `LASER_FIRE_AUTO_EN`; with it, back-to-back shots spaced 16 cycles apart until `ammo`=0.
- `resetn` pulled low in the 5th cycle of FIRE → `fire_n`=1 in the same cycle, `ammo`=3, state IDLE after release.

Source files
------------

// File: rtl/laser_fire_ctrl_pkg.sv
// Shared definitions for the laser trigger controller.
//   state_e            : FSM state encoding (2-bit)
//   CntWidth / cnt_t   : width and type of the phase and debounce counters
//   LaserDriverTimeout : laser driver on-time limit; a shot must be shorter than this
package laser_fire_ctrl_pkg;

  localparam int unsigned CntWidth           = 32;
  localparam int unsigned LaserDriverTimeout = 150000000;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFire     = 2'd1,
    StCooldown = 2'd2,
    StReload   = 2'd3
  } state_e;

endpackage

// File: rtl/laser_fire_ctrl_button_debounce.sv
// button_debounce: 2-flop synchronizer followed by a stability counter.
//   clock, resetn : clock and asynchronous active-low reset
//   button        : raw button, asynchronous to clock, 1 = pressed
//   level         : debounced level, changes after DEBOUNCE_CYCLES equal samples
//   press         : single-cycle pulse on a debounced 0->1 transition
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic button,
  output logic level,
  output logic press
);
  import laser_fire_ctrl_pkg::*;

  if (DEBOUNCE_CYCLES == 0) begin : g_deb_chk
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  localparam cnt_t DebLast = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic press_q, press_d;
  cnt_t cnt_q, cnt_d;

  // Counter runs only while the synchronized sample disagrees with the accepted
  // level; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DebLast) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/laser_fire_ctrl.sv
// laser_fire_ctrl: debounces trigger/reload buttons, meters shots against an ammo
// count and drives the active-low laser enable with a fixed burst plus cooldown.
//   clock, resetn : clock and asynchronous active-low reset
//   trigger       : raw trigger button (1 = pressed)
//   reload        : raw reload button (1 = pressed)
//   fire_n        : laser enable to driver, 0 = on (low exactly while firing)
//   ammo          : remaining shots
//   busy          : 1 while firing, cooling down or reloading
//   empty         : 1 when ammo is 0
// Build option: define LASER_FIRE_AUTO_EN for auto-fire while the trigger is held.
module laser_fire_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SHOT_CYCLES     = 25000000,
  parameter int unsigned COOLDOWN_CYCLES = 50000000,
  parameter int unsigned RELOAD_CYCLES   = 100000000,
  parameter int unsigned AMMO_MAX        = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       trigger,
  input  logic       reload,
  output logic       fire_n,
  output logic [3:0] ammo,
  output logic       busy,
  output logic       empty
);
  import laser_fire_ctrl_pkg::*;

  if (SHOT_CYCLES == 0 || SHOT_CYCLES >= LaserDriverTimeout) begin : g_shot_chk
    $error("SHOT_CYCLES must be 1..LaserDriverTimeout-1");
  end
  if (COOLDOWN_CYCLES == 0 || RELOAD_CYCLES == 0) begin : g_phase_chk
    $error("COOLDOWN_CYCLES and RELOAD_CYCLES must be at least 1");
  end
  if (AMMO_MAX == 0 || AMMO_MAX > 15) begin : g_ammo_chk
    $error("AMMO_MAX must be 1..15");
  end

  localparam cnt_t       ShotLast   = cnt_t'(SHOT_CYCLES - 1);
  localparam cnt_t       CoolLast   = cnt_t'(COOLDOWN_CYCLES - 1);
  localparam cnt_t       ReloadLast = cnt_t'(RELOAD_CYCLES - 1);
  localparam logic [3:0] AmmoFull   = 4'(AMMO_MAX);

  logic trig_level, trig_press;
  logic reload_level, reload_press;
  logic unused_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig_deb (
    .clock (clock),
    .resetn(resetn),
    .button(trigger),
    .level (trig_level),
    .press (trig_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reload_deb (
    .clock (clock),
    .resetn(resetn),
    .button(reload),
    .level (reload_level),
    .press (reload_press)
  );

  // Reload level is never needed; trigger level only feeds auto-fire.
  assign unused_level = ^{trig_level, reload_level};

  state_e     state_q, state_d;
  cnt_t       phase_q, phase_d;
  logic [3:0] ammo_q, ammo_d;
  logic       fire_n_q, fire_n_d;
  logic       busy_q, busy_d;
  logic       empty_q, empty_d;

  // State register, plus the registered outputs and phase counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      ammo_q   <= AmmoFull;
      fire_n_q <= 1'b1;
      busy_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ammo_q   <= ammo_d;
      fire_n_q <= fire_n_d;
      busy_q   <= busy_d;
      empty_q  <= empty_d;
    end
  end

  // Next state. Press events outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Trigger wins over a simultaneous reload press.
        if (trig_press && ammo_q != '0) begin
          state_d = StFire;
        end else if (reload_press) begin
          state_d = StReload;
        end
      end
      StFire: begin
        if (phase_q == ShotLast) state_d = StCooldown;
      end
      StCooldown: begin
        if (phase_q == CoolLast) begin
`ifdef LASER_FIRE_AUTO_EN
          if (trig_level && ammo_q != '0) state_d = StFire;
          else state_d = StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      StReload: begin
        if (phase_q == ReloadLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the upcoming state so that, once registered, they
  // line up with the state and ammo of the same cycle.
  always_comb begin
    phase_d = phase_q + cnt_t'(1);
    if (state_d != state_q || state_q == StIdle) phase_d = '0;

    ammo_d = ammo_q;
    if (state_d == StFire && state_q != StFire) begin
      ammo_d = ammo_q - 4'd1;
    end else if (state_q == StReload && state_d == StIdle) begin
      ammo_d = AmmoFull;
    end

    fire_n_d = (state_d != StFire);
    busy_d   = (state_d != StIdle);
    empty_d  = (ammo_d == 4'd0);
  end

  assign fire_n = fire_n_q;
  assign ammo   = ammo_q;
  assign busy   = busy_q;
  assign empty  = empty_q;

endmodule
